// File: rtl/call_return_ctrl.sv
// rtl/call_return_ctrl.sv - CALL/RET sequencer driving an external return stack.
// Optional sticky overflow/underflow flags enabled by CALLRET_ERR_FLAGS_EN.
module call_return_ctrl #(
  parameter int WIDTH      = 18,
  parameter int DEPTH_LOG2 = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  is_call,
  input  logic                  is_ret,
  input  logic [WIDTH-1:0]      pc_plus1,
  input  logic [WIDTH-1:0]      call_target,
  input  logic [WIDTH-1:0]      stack_top,
  output logic                  push,
  output logic                  pop,
  output logic [WIDTH-1:0]      stack_pc,
  output logic [WIDTH-1:0]      next_pc,
  output logic                  next_pc_valid,
  output logic                  stall,
  output logic [DEPTH_LOG2:0]   depth,
  output logic                  overflow,
  output logic                  underflow
);

  typedef enum logic [1:0] {IDLE, CALL_DONE, RET_WAIT} state_t;

  localparam logic [DEPTH_LOG2:0] CAPACITY = {1'b1, {DEPTH_LOG2{1'b0}}};

  state_t             state, state_n;
  logic [WIDTH-1:0]   target_q, target_n;
  logic               fall_q, fall_n;
  logic               push_n, pop_n, valid_n;
  logic [WIDTH-1:0]   stack_pc_n, next_pc_n;
  logic [DEPTH_LOG2:0] depth_n;
  logic               ovf_q, ovf_n, unf_q, unf_n;

  always_comb begin
    state_n    = state;
    target_n   = target_q;
    fall_n     = fall_q;
    push_n     = 1'b0;
    pop_n      = 1'b0;
    valid_n    = 1'b0;
    stack_pc_n = stack_pc;
    next_pc_n  = next_pc;
    depth_n    = depth;
    ovf_n      = ovf_q;
    unf_n      = unf_q;
    case (state)
      IDLE: begin
        // CALL has priority; a simultaneous RET is simply dropped.
        if (is_call) begin
          state_n  = CALL_DONE;
          target_n = call_target;
          if (depth != CAPACITY) begin
            push_n     = 1'b1;
            stack_pc_n = pc_plus1;
            depth_n    = depth + 1'b1;
          end else begin
`ifdef CALLRET_ERR_FLAGS_EN
            ovf_n = 1'b1;
`endif
          end
        end else if (is_ret) begin
          state_n = RET_WAIT;
          if (depth != '0) begin
            pop_n   = 1'b1;
            depth_n = depth - 1'b1;
            fall_n  = 1'b0;
          end else begin
            // Empty stack: fall through to the instruction after the RET.
            fall_n   = 1'b1;
            target_n = pc_plus1;
`ifdef CALLRET_ERR_FLAGS_EN
            unf_n = 1'b1;
`endif
          end
        end
      end
      CALL_DONE: begin
        next_pc_n = target_q;
        valid_n   = 1'b1;
        state_n   = IDLE;
      end
      RET_WAIT: begin
        next_pc_n = fall_q ? target_q : stack_top;
        valid_n   = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      target_q      <= '0;
      fall_q        <= 1'b0;
      push          <= 1'b0;
      pop           <= 1'b0;
      next_pc_valid <= 1'b0;
      stack_pc      <= '0;
      next_pc       <= '0;
      depth         <= '0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
    end else begin
      state         <= state_n;
      target_q      <= target_n;
      fall_q        <= fall_n;
      push          <= push_n;
      pop           <= pop_n;
      next_pc_valid <= valid_n;
      stack_pc      <= stack_pc_n;
      next_pc       <= next_pc_n;
      depth         <= depth_n;
      ovf_q         <= ovf_n;
      unf_q         <= unf_n;
    end
  end

  assign stall     = (state != IDLE);
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_call_return_ctrl.sv
// tb/tb_call_return_ctrl.sv - scoreboard bench for call_return_ctrl (DEPTH_LOG2=2).
module tb_call_return_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        is_call = 1'b0, is_ret = 1'b0;
  logic [17:0] pc_plus1 = '0, call_target = '0, stack_top = '0;
  logic        push, pop, next_pc_valid, stall, overflow, underflow;
  logic [17:0] stack_pc, next_pc;
  logic [2:0]  depth;

`ifdef CALLRET_ERR_FLAGS_EN
  localparam logic EXP_FLAG = 1'b1;
`else
  localparam logic EXP_FLAG = 1'b0;
`endif

  call_return_ctrl #(.WIDTH(18), .DEPTH_LOG2(2)) dut (
    .clk(clk), .rst(rst), .is_call(is_call), .is_ret(is_ret),
    .pc_plus1(pc_plus1), .call_target(call_target), .stack_top(stack_top),
    .push(push), .pop(pop), .stack_pc(stack_pc), .next_pc(next_pc),
    .next_pc_valid(next_pc_valid), .stall(stall), .depth(depth),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  kind;   // 0 push, 1 pop, 2 next_pc
    logic [17:0] val;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_kind(input string name, input logic [1:0] kind, input logic [17:0] val);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected strobe, got 1 expected none", name);
    end else begin
      e = q.pop_front();
      chk({name, " order"}, {30'd0, kind}, {30'd0, e.kind});
      if (kind != 2'd1) chk({name, " value"}, {14'd0, val}, {14'd0, e.val});
    end
  endtask

  // Monitor: every strobe from the DUT consumes one scoreboard entry in order.
  always @(negedge clk) begin
    if (push && pop) chk("push_pop_exclusive", 32'd1, 32'd0);
    if (push) expect_kind("push", 2'd0, stack_pc);
    if (pop) expect_kind("pop", 2'd1, 18'd0);
    if (next_pc_valid) expect_kind("next_pc", 2'd2, next_pc);
  end

  task automatic op(input string name, input logic c, input logic r,
                    input logic [17:0] pc1, input logic [17:0] tgt, input logic [17:0] st,
                    input logic hold, input logic exp_push, input logic exp_pop,
                    input logic [17:0] exp_pc, input int exp_depth);
    int n;
    if (exp_push) q.push_back({2'd0, pc1});
    if (exp_pop) q.push_back({2'd1, 18'd0});
    q.push_back({2'd2, exp_pc});
    is_call = c; is_ret = r; pc_plus1 = pc1; call_target = tgt; stack_top = st;
    @(negedge clk);
    if (!hold) begin is_call = 1'b0; is_ret = 1'b0; end
    n = 0;
    while (stall && n < 8) begin @(negedge clk); n++; end
    if (n >= 8) begin
      checks++; errors++;
      $display("FAIL %s timeout: stall still 1 expected 0", name);
    end
    is_call = 1'b0; is_ret = 1'b0;
    chk({name, " depth"}, {29'd0, depth}, exp_depth);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, " depth"}, {29'd0, depth}, 32'd0);
    chk({name, " push"}, {31'd0, push}, 32'd0);
    chk({name, " pop"}, {31'd0, pop}, 32'd0);
    chk({name, " valid"}, {31'd0, next_pc_valid}, 32'd0);
    chk({name, " stall"}, {31'd0, stall}, 32'd0);
    chk({name, " next_pc"}, {14'd0, next_pc}, 32'd0);
    chk({name, " stack_pc"}, {14'd0, stack_pc}, 32'd0);
    chk({name, " overflow"}, {31'd0, overflow}, 32'd0);
    chk({name, " underflow"}, {31'd0, underflow}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset");

    op("call1", 1, 0, 18'h00010, 18'h00200, 18'h0, 0, 1, 0, 18'h00200, 1);
    op("ret1",  0, 1, 18'h00201, 18'h0, 18'h00010, 0, 0, 1, 18'h00010, 0);
    op("ret_empty", 0, 1, 18'h00055, 18'h0, 18'h3ffff, 0, 0, 0, 18'h00055, 0);
    chk("underflow_sticky", {31'd0, underflow}, {31'd0, EXP_FLAG});
    chk("overflow_clear", {31'd0, overflow}, 32'd0);

    op("fill1", 1, 0, 18'h00020, 18'h00300, 18'h0, 0, 1, 0, 18'h00300, 1);
    op("fill2", 1, 0, 18'h00021, 18'h00310, 18'h0, 0, 1, 0, 18'h00310, 2);
    op("fill3", 1, 0, 18'h00022, 18'h00320, 18'h0, 0, 1, 0, 18'h00320, 3);
    op("fill4", 1, 0, 18'h00023, 18'h00330, 18'h0, 0, 1, 0, 18'h00330, 4);
    op("call_full", 1, 0, 18'h00024, 18'h00340, 18'h0, 0, 0, 0, 18'h00340, 4);
    chk("overflow_set", {31'd0, overflow}, {31'd0, EXP_FLAG});

    op("ret_full", 0, 1, 18'h00341, 18'h0, 18'h00023, 0, 0, 1, 18'h00023, 3);
    chk("overflow_sticky", {31'd0, overflow}, {31'd0, EXP_FLAG});
    op("call_and_ret", 1, 1, 18'h00040, 18'h00400, 18'h0, 0, 1, 0, 18'h00400, 4);
    op("ret_hold", 0, 1, 18'h00401, 18'h0, 18'h00040, 1, 0, 1, 18'h00040, 3);

    // Reset lands while the DUT is in RET_WAIT; the aborted RET must not complete.
    q.push_back({2'd1, 18'd0});
    is_ret = 1'b1; stack_top = 18'h00022; pc_plus1 = 18'h00500;
    @(negedge clk);
    is_ret = 1'b0;
    rst = 1'b1; is_call = 1'b1; call_target = 18'h00777;
    @(negedge clk);
    rst = 1'b0; is_call = 1'b0;
    check_all_zero("reset_in_ret_wait");
    @(negedge clk);
    chk("post_reset push", {31'd0, push}, 32'd0);
    chk("post_reset valid", {31'd0, next_pc_valid}, 32'd0);

    op("call_after_reset", 1, 0, 18'h00060, 18'h00600, 18'h0, 0, 1, 0, 18'h00600, 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/call_return_ctrl.md
CALL_RETURN_CTRL -- requirements
Module: call_return_ctrl

Interface
REQ-001 Parameter WIDTH, default 18, is the PC width in bits.
REQ-002 Parameter DEPTH_LOG2, default 15, is log2 of return-stack capacity (capacity = 2**DEPTH_LOG2 = 32768).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 is_call  input  1  decoded CALL in the current cycle.
REQ-006 is_ret  input  1  decoded RET in the current cycle.
REQ-007 pc_plus1  input  WIDTH  return address (PC of the call/ret plus 1).
REQ-008 call_target  input  WIDTH  CALL destination.
REQ-009 stack_top  input  WIDTH  top-of-stack value from the return stack.
REQ-010 push  output  1  one-cycle push strobe to the return stack.
REQ-011 pop  output  1  one-cycle pop strobe to the return stack.
REQ-012 stack_pc  output  WIDTH  value to push, driven to the stack PC input.
REQ-013 next_pc  output  WIDTH  redirected fetch PC.
REQ-014 next_pc_valid  output  1  one-cycle strobe qualifying next_pc.
REQ-015 stall  output  1  fetch must hold; is_call/is_ret ignored while high.
REQ-016 depth  output  DEPTH_LOG2+1  current number of stacked entries.
REQ-017 overflow  output  1  sticky: CALL seen at full.
REQ-018 underflow  output  1  sticky: RET seen at empty.

Function
REQ-019 FSM states SHALL be IDLE, CALL_DONE and RET_WAIT.
REQ-020 IDLE + is_call, depth < 2**DEPTH_LOG2: push=1 and stack_pc=pc_plus1 that cycle (registered); next state CALL_DONE; depth+1.
REQ-021 CALL_DONE: next_pc=latched call_target, next_pc_valid=1 for one cycle, push=0, back to IDLE; CALL latency = 2 edges from is_call.
REQ-022 IDLE + is_ret, depth > 0: pop=1 for one cycle; stall=1; next state RET_WAIT; depth-1.
REQ-023 RET_WAIT: sample stack_top into next_pc, next_pc_valid=1 the following cycle, stall=1 until then, back to IDLE.
REQ-024 is_call and is_ret together in IDLE: CALL SHALL win; RET dropped with no pop.
REQ-025 CALL at full (depth == 2**DEPTH_LOG2): no push, depth unchanged, overflow set, jump to call_target still issued via CALL_DONE.
REQ-026 RET at empty (depth == 0): no pop, underflow set, next_pc=pc_plus1 with next_pc_valid after one cycle (fall-through).
REQ-027 is_call/is_ret SHALL be ignored outside IDLE; stall=1 in CALL_DONE and RET_WAIT.
REQ-028 push and pop SHALL never be high in the same cycle; each strobe lasts exactly one cycle.
REQ-029 depth SHALL never wrap; increments and decrements are bounded by REQ-025/026.

Reset
REQ-030 rst high at an edge SHALL force IDLE, depth=0, push=0, pop=0, next_pc_valid=0, stall=0, next_pc=0, stack_pc=0, overflow=0, underflow=0.
REQ-031 rst SHALL override any in-flight CALL_DONE/RET_WAIT; no strobe issued in the reset cycle or after it for the aborted operation.
REQ-032 Inputs are ignored in the cycle rst is high; first accepted op is the first edge with rst low.

Configuration
REQ-033 Macro CALLRET_ERR_FLAGS_EN defined: overflow/underflow behave per REQ-025/026 and clear only on rst.
REQ-034 Macro undefined: overflow and underflow tied 0; push/pop suppression at full/empty and fall-through behaviour unchanged.

Verification
REQ-035 rst 1 cycle, then is_call, pc_plus1=0x00010, call_target=0x00200 -> push=1, stack_pc=0x00010 next edge; next_pc=0x00200, next_pc_valid=1 one cycle later; depth=1.
REQ-036 After REQ-035, is_ret with stack_top=0x00010 -> pop=1 one cycle, stall=1, then next_pc=0x00010, next_pc_valid=1; depth=0.
REQ-037 depth=0, is_ret, pc_plus1=0x00055 -> pop never asserted, next_pc=0x00055 valid, underflow=1 (0 with macro undefined).
REQ-038 DEPTH_LOG2=2, four CALLs then fifth CALL -> no fifth push, depth=4, overflow=1, next_pc=fifth call_target.
REQ-039 is_call and is_ret same cycle -> push only, no pop; rst asserted in RET_WAIT -> no next_pc_valid, all outputs zero next cycle.
